// File: rtl/safecrack_btn_encoder.sv
// rtl/safecrack_btn_encoder.sv - keypad front-end: sync, debounce, one-cold encode, multi-press reject
// Optional: define KEY_LEVEL_EN to hold btn at the pressed code until the release debounce completes.
module safecrack_btn_encoder #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic [3:0] btn,
  output logic       btn_valid,
  output logic       multi_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    EMIT      = 3'd2,
    WAIT_REL  = 3'd3,
    DEB_REL   = 3'd4
  } state_e;

  localparam logic [3:0]       NO_KEY  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
`ifdef KEY_LEVEL_EN
  localparam bit LEVEL = 1'b1;
`else
  localparam bit LEVEL = 1'b0;
`endif

  logic [3:0]       sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       btn_q, btn_d;
  logic             valid_q, valid_d;
  logic             merr_q, merr_d;
  logic             busy_q, busy_d;
  logic [3:0]       cand_act;
  logic             cand_one_cold;

  // Exactly one zero bit in the candidate pattern.
  assign cand_act      = ~cand_q;
  assign cand_one_cold = (cand_act != 4'b0000) && ((cand_act & (cand_act - 4'b0001)) == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= NO_KEY;
      sync2_q <= NO_KEY;
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= NO_KEY;
      btn_q   <= NO_KEY;
      valid_q <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      btn_q   <= btn_d;
      valid_q <= valid_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    btn_d   = LEVEL ? btn_q : NO_KEY;
    valid_d = 1'b0;
    merr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        btn_d = NO_KEY;
        if (sync2_q != NO_KEY) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (sync2_q != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          if (cand_one_cold) begin
            state_d = EMIT;
            btn_d   = cand_q;
            valid_d = 1'b1;
          end else begin
            merr_d  = 1'b1;
            state_d = WAIT_REL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: state_d = WAIT_REL;
      WAIT_REL: begin
        // Anything other than a full release, including extra buttons, is ignored here.
        if (sync2_q == NO_KEY) begin
          cnt_d   = '0;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (sync2_q != NO_KEY) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          btn_d   = NO_KEY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        btn_d   = NO_KEY;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign btn       = btn_q;
  assign btn_valid = valid_q;
  assign multi_err = merr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_safecrack_btn_encoder.sv
// tb/tb_safecrack_btn_encoder.sv - bench for safecrack_btn_encoder (DB_CYCLES=4), honours KEY_LEVEL_EN
module tb_safecrack_btn_encoder;

  localparam int DB = 4;
  localparam logic [3:0] NK = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_n = NK;
  logic [3:0] btn;
  logic       btn_valid, multi_err, busy;

  safecrack_btn_encoder #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .btn(btn), .btn_valid(btn_valid), .multi_err(multi_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: a pattern is accepted once seen on DB+1 consecutive edges;
  // an edge that breaks a run only aborts it. Emission costs one extra blind edge.
  logic [3:0] m_s1, m_s2, m_cand, m_hold;
  int         m_run;
  bit         m_locked, m_skip;
  logic [3:0] e_btn;
  logic       e_valid, e_merr, e_busy;

  int edge_no, valid_cnt, valid_edge, merr_cnt, merr_edge;

  function automatic bit one_cold(input logic [3:0] v);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) z++;
    return z == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_s1 = NK; m_s2 = NK; m_cand = NK; m_hold = NK;
    m_run = 0; m_locked = 0; m_skip = 0;
    e_btn = NK; e_valid = 0; e_merr = 0; e_busy = 0;
  endtask

  task automatic model_edge(input logic [3:0] kin);
    logic [3:0] ks;
    ks = m_s2; m_s2 = m_s1; m_s1 = kin;
    e_valid = 0; e_merr = 0;
    if (m_skip) m_skip = 0;
    else if (!m_locked) begin
      if (m_run == 0) begin
        if (ks != NK) begin m_cand = ks; m_run = 1; end
      end else if (ks != m_cand) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB + 1) begin
          m_locked = 1; m_run = 0;
          if (one_cold(m_cand)) begin e_valid = 1; m_skip = 1; m_hold = m_cand; end
          else e_merr = 1;
        end
      end
    end else begin
      if (m_run == 0) begin
        if (ks == NK) m_run = 1;
      end else if (ks != NK) m_run = 0;
      else begin
        m_run++;
        if (m_run == DB + 1) begin m_locked = 0; m_run = 0; m_hold = NK; end
      end
    end
    e_busy = m_locked || (m_run > 0);
`ifdef KEY_LEVEL_EN
    e_btn = m_hold;
`else
    e_btn = e_valid ? m_cand : NK;
`endif
  endtask

  task automatic step(input logic [3:0] k);
    key_n = k;
    @(posedge clk);
    edge_no++;
    if (rst) model_reset(); else model_edge(k);
    #1;
    if (btn_valid === 1'b1) begin valid_cnt++; if (valid_edge < 0) valid_edge = edge_no; end
    if (multi_err === 1'b1) begin merr_cnt++; if (merr_edge < 0) merr_edge = edge_no; end
    chk("btn", btn, e_btn);
    chk("btn_valid", btn_valid, e_valid);
    chk("multi_err", multi_err, e_merr);
    chk("busy", busy, e_busy);
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic reset_step(input logic [3:0] k);
    rst = 1'b1; step(k); rst = 1'b0;
  endtask

  task automatic mark();
    edge_no = 0; valid_cnt = 0; valid_edge = -1; merr_cnt = 0; merr_edge = -1;
  endtask

  initial begin
    model_reset();
    mark();
    reset_step(NK);
    reset_step(NK);

    // Clean single press of button 1.
    mark();
    hold(4'b1101, 20);
    hold(NK, 12);
    chk("p1_strobes", valid_cnt, 1);
    chk("p1_strobe_edge", valid_edge, 7);

    // Bounce then stable press of button 0.
    mark();
    for (int r = 0; r < 3; r++) begin hold(4'b1110, 2); hold(NK, 2); end
    edge_no = 0; valid_edge = -1;
    hold(4'b1110, 15);
    hold(NK, 12);
    chk("bounce_strobes", valid_cnt, 1);
    chk("bounce_strobe_edge", valid_edge, 7);

    // Two buttons at once.
    mark();
    hold(4'b1100, 10);
    hold(NK, 12);
    chk("multi_count", merr_cnt, 1);
    chk("multi_edge", merr_edge, 7);
    chk("multi_no_strobe", valid_cnt, 0);

    // Hold button 0, slide to button 2, release, press button 2 again.
    mark();
    hold(4'b1110, 10);
    hold(4'b1011, 10);
    hold(NK, 12);
    chk("switch_strobes", valid_cnt, 1);
    hold(4'b1011, 12);
    hold(NK, 12);
    chk("repress_strobes", valid_cnt, 2);

    // Reset during press debounce with the button still held.
    mark();
    hold(4'b0111, 4);
    reset_step(4'b0111);
    mark();
    hold(4'b0111, 10);
    hold(NK, 12);
    chk("rst_strobes", valid_cnt, 1);
    chk("rst_strobe_edge", valid_edge, 7);

    // Level-mode style scenario (checked per cycle against the model in either build).
    mark();
    hold(4'b1110, 15);
    hold(NK, 12);
    chk("lvl_strobes", valid_cnt, 1);

    // Randomized patterns and hold lengths with occasional resets.
    for (int s = 0; s < 80; s++) begin
      logic [3:0] pat;
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      pat = NK;
      else if (r < 7) pat = ~(4'b0001 << $urandom_range(0, 3));
      else            pat = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) reset_step(pat);
      hold(pat, $urandom_range(1, 10));
    end
    hold(NK, 14);
    chk("final_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
